// File: rtl/text_char_buffer_pkg.sv
// Shared constants for the text character store and the text renderer.
// The renderer derives cell coordinates from FONT_W/FONT_H, so both sides agree on cell size.
package text_char_buffer_pkg;

  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_FF    = 7'h0C;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;
  localparam int FONT_W   = 8;
  localparam int FONT_H   = 16;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

endpackage

// File: rtl/text_char_buffer_char_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
// Reads return the old contents when they hit the cell being written in the same cycle.
module char_ram #(
  parameter int AW = 12,
  parameter int DW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_char_buffer.sv
// Screen character store: cursor-driven write side with CR/BS/FF editing, 1-clk read side.
// After reset or FF, a sweep fills every cell with a space, one per clk, while busy is high.
module text_char_buffer
  import text_char_buffer_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int AW   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_pulse,
  input  logic [6:0] wr_char,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [6:0] rd_char,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  localparam logic [AW-1:0] COLS_A    = AW'(COLS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);
  localparam logic [6:0]    COLS_L    = 7'(COLS);
  localparam logic [4:0]    ROWS_L    = 5'(ROWS);
  localparam logic [6:0]    COL_MAX   = 7'(COLS - 1);
  localparam logic [4:0]    ROW_MAX   = 5'(ROWS - 1);

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    return AW'(r) * COLS_A + AW'(c);
  endfunction

  logic [0:0]    state;
  logic [AW-1:0] clr_addr;
  logic          rd_oor_q;
  logic [6:0]    ram_rdata;

  logic          take;
  logic          is_cr, is_bs, is_ff;
  logic [6:0]    bs_col, nx_col;
  logic [4:0]    bs_row, nx_row;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [6:0]    ram_wdata;
  logic          rd_oor;

  assign busy  = (state == ST_CLEAR);
  assign take  = (state == ST_IDLE) && wr_pulse;
  assign is_cr = (wr_char == CH_CR);
  assign is_bs = (wr_char == CH_BS);
  assign is_ff = (wr_char == CH_FF);

  // Backspace target cell; stays put at the top-left corner.
  always_comb begin
    bs_col = cursor_col;
    bs_row = cursor_row;
    if (cursor_col != 7'd0) begin
      bs_col = cursor_col - 7'd1;
    end else if (cursor_row != 5'd0) begin
      bs_col = COL_MAX;
      bs_row = cursor_row - 5'd1;
    end
  end

  // Advance after a printable character; the last cell wraps to the first, no scrolling.
  always_comb begin
    nx_col = cursor_col + 7'd1;
    nx_row = cursor_row;
    if (cursor_col == COL_MAX) begin
      nx_col = 7'd0;
      nx_row = (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cell_addr(cursor_row, cursor_col);
    ram_wdata = wr_char;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = CH_SPACE;
    end else if (take && is_bs) begin
      ram_we    = 1'b1;
      ram_waddr = cell_addr(bs_row, bs_col);
      ram_wdata = CH_SPACE;
    end else if (take && !is_cr && !is_ff) begin
      ram_we    = 1'b1;
    end
  end

  assign rd_oor = (rd_col >= COLS_L) || (rd_row >= ROWS_L);

  char_ram #(.AW(AW), .DW(7)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (cell_addr(rd_row, rd_col)),
    .rdata (ram_rdata)
  );

  assign rd_char = rd_oor_q ? CH_SPACE : ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      cursor_col <= 7'd0;
      cursor_row <= 5'd0;
      rd_oor_q   <= 1'b1;
    end else begin
      rd_oor_q <= rd_oor;
      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
        if (clr_addr == LAST_ADDR) state <= ST_IDLE;
      end else if (take) begin
        if (is_cr) begin
          cursor_col <= 7'd0;
          cursor_row <= (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
        end else if (is_bs) begin
          cursor_col <= bs_col;
          cursor_row <= bs_row;
        end else if (is_ff) begin
          state      <= ST_CLEAR;
          clr_addr   <= '0;
          cursor_col <= 7'd0;
          cursor_row <= 5'd0;
        end else begin
          cursor_col <= nx_col;
          cursor_row <= nx_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_char_buffer.sv
// Directed bench for text_char_buffer: vector table for the editing and read paths,
// hand-written sequences for the clear sweeps, reset restart and end-of-screen wrap.
module tb_text_char_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_pulse;
  logic [6:0] wr_char;
  logic [6:0] rd_col;
  logic [4:0] rd_row;
  logic [6:0] rd_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  text_char_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .wr_pulse   (wr_pulse),
    .wr_char    (wr_char),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  typedef struct {
    logic       pulse;
    logic [6:0] wch;
    logic [4:0] rrow;
    logic [6:0] rcol;
    logic [6:0] exp_rd;
    logic [4:0] exp_row;
    logic [6:0] exp_col;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] c);
    wr_pulse = 1'b1;
    wr_char  = c;
    step();
    wr_pulse = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] r, input logic [6:0] c,
                        input logic [6:0] exp);
    rd_row = r;
    rd_col = c;
    step();
    chk(nm, int'(rd_char), int'(exp));
  endtask

  task automatic cur_chk(input string nm, input logic [4:0] r, input logic [6:0] c);
    chk({nm, "_row"}, int'(cursor_row), int'(r));
    chk({nm, "_col"}, int'(cursor_col), int'(c));
  endtask

  // Count clocks until busy drops; called right after the edge that raised busy.
  task automatic count_busy(input string nm, input int drop_at);
    int n = 0;
    while (busy && n < 3000) begin
      wr_pulse = (n == drop_at);
      wr_char  = 7'h51;
      step();
      n++;
    end
    wr_pulse = 1'b0;
    chk(nm, n, 2400);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //          pulse wch    row    col    rd     cur_row cur_col
    vt[0]  = '{1'b0, 7'h00, 5'd0,  7'd0,  7'h20, 5'd0, 7'd0};
    vt[1]  = '{1'b0, 7'h00, 5'd29, 7'd79, 7'h20, 5'd0, 7'd0};
    vt[2]  = '{1'b0, 7'h00, 5'd15, 7'd40, 7'h20, 5'd0, 7'd0};
    vt[3]  = '{1'b1, 7'h41, 5'd0,  7'd0,  7'h20, 5'd0, 7'd1};  // read-first: old space
    vt[4]  = '{1'b1, 7'h42, 5'd0,  7'd0,  7'h41, 5'd0, 7'd2};
    vt[5]  = '{1'b0, 7'h00, 5'd0,  7'd1,  7'h42, 5'd0, 7'd2};
    vt[6]  = '{1'b1, 7'h43, 5'd0,  7'd2,  7'h20, 5'd0, 7'd3};
    vt[7]  = '{1'b1, 7'h44, 5'd0,  7'd2,  7'h43, 5'd0, 7'd4};
    vt[8]  = '{1'b1, 7'h45, 5'd0,  7'd3,  7'h44, 5'd0, 7'd5};
    vt[9]  = '{1'b1, 7'h0D, 5'd0,  7'd4,  7'h45, 5'd1, 7'd0};  // CR
    vt[10] = '{1'b0, 7'h00, 5'd0,  7'd5,  7'h20, 5'd1, 7'd0};
    vt[11] = '{1'b0, 7'h00, 5'd1,  7'd0,  7'h20, 5'd1, 7'd0};
    vt[12] = '{1'b1, 7'h08, 5'd0,  7'd79, 7'h20, 5'd0, 7'd79}; // BS across row
    vt[13] = '{1'b1, 7'h4D, 5'd0,  7'd79, 7'h20, 5'd1, 7'd0};  // col wrap
    vt[14] = '{1'b0, 7'h00, 5'd0,  7'd79, 7'h4D, 5'd1, 7'd0};
    vt[15] = '{1'b1, 7'h08, 5'd0,  7'd79, 7'h4D, 5'd0, 7'd79}; // BS erases, read-first
    vt[16] = '{1'b0, 7'h00, 5'd0,  7'd79, 7'h20, 5'd0, 7'd79};
    vt[17] = '{1'b1, 7'h0D, 5'd0,  7'd0,  7'h41, 5'd1, 7'd0};

    reset    = 1'b1;
    wr_pulse = 1'b0;
    wr_char  = 7'h00;
    rd_col   = 7'd0;
    rd_row   = 5'd0;
    step();
    step();
    chk("reset_busy", int'(busy), 1);
    chk("reset_rd_char", int'(rd_char), 32'h20);
    cur_chk("reset_cursor", 5'd0, 7'd0);

    reset = 1'b0;
    count_busy("reset_sweep_len", 5);
    cur_chk("drop_during_busy", 5'd0, 7'd0);

    for (int i = 0; i < 18; i++) begin
      wr_pulse = vt[i].pulse;
      wr_char  = vt[i].wch;
      rd_row   = vt[i].rrow;
      rd_col   = vt[i].rcol;
      step();
      wr_pulse = 1'b0;
      chk($sformatf("vec%0d_rd", i), int'(rd_char), int'(vt[i].exp_rd));
      cur_chk($sformatf("vec%0d_cur", i), vt[i].exp_row, vt[i].exp_col);
    end

    // Walk to the last cell and wrap.
    for (int i = 0; i < 28; i++) send(7'h0D);
    cur_chk("cr_to_row29", 5'd29, 7'd0);
    for (int i = 0; i < 79; i++) send(7'h61);
    cur_chk("fill_row29", 5'd29, 7'd79);
    send(7'h5A);
    cur_chk("last_cell_wrap", 5'd0, 7'd0);
    rd_chk("cell_29_79", 5'd29, 7'd79, 7'h5A);
    rd_chk("cell_29_0", 5'd29, 7'd0, 7'h61);
    rd_chk("oor_col85", 5'd29, 7'd85, 7'h20);
    rd_chk("oor_row30", 5'd30, 7'd0, 7'h20);
    rd_chk("cell_0_0_kept", 5'd0, 7'd0, 7'h41);

    send(7'h08);
    cur_chk("bs_at_origin", 5'd0, 7'd0);
    rd_chk("bs_origin_erase", 5'd0, 7'd0, 7'h20);
    rd_chk("cell_0_1_kept", 5'd0, 7'd1, 7'h42);

    send(7'h46);
    send(7'h0C);
    chk("ff_busy", int'(busy), 1);
    cur_chk("ff_cursor", 5'd0, 7'd0);
    count_busy("ff_sweep_len", -1);
    begin
      int bad = 0;
      for (int r = 0; r < 30; r++) begin
        for (int c = 0; c < 80; c++) begin
          rd_row = 5'(r);
          rd_col = 7'(c);
          step();
          if (rd_char != 7'h20) bad++;
        end
      end
      chk("ff_cells_not_space", bad, 0);
    end

    send(7'h47);
    send(7'h0C);
    for (int i = 0; i < 1000; i++) step();
    chk("mid_sweep_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy("restart_sweep_len", -1);
    cur_chk("restart_cursor", 5'd0, 7'd0);
    rd_chk("restart_cell_0_0", 5'd0, 7'd0, 7'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
